// File: rtl/pingpong_stream_router.sv
// Ping-pong bank writer: turns a valid/ready pixel stream into registered demux data/select
// plus per-bank write strobes, filling two banks alternately in blocks of BLOCK_LEN pixels.
module pingpong_stream_router #(
  parameter int DATA_WIDTH = 8,
  parameter int BLOCK_LEN  = 784,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic                  bank_release_1,
  input  logic                  bank_release_2,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  sel,
  output logic                  wr_en_1,
  output logic                  wr_en_2,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  bank_full_1,
  output logic                  bank_full_2,
  output logic                  block_done
);

  typedef enum logic {FILL = 1'b0, STALL = 1'b1} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(BLOCK_LEN - 1);

  state_t                  state_q, state_d;
  logic                    tgt_q, tgt_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [1:0]              full_q, full_d;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    sel_q, sel_d;
  logic [1:0]              wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic                    done_q, done_d;
  logic [1:0]              rel;
  logic                    accept;

  assign rel       = {bank_release_2, bank_release_1};
  // Pure decode of registered state; reset gating keeps upstream from handing off beats mid-reset.
  assign din_ready = (state_q == FILL) && !reset;
  assign accept    = din_valid && din_ready;

  always_comb begin
    state_d   = state_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    full_d    = full_q & ~rel;
    dout_d    = dout_q;
    sel_d     = sel_q;
    wr_addr_d = wr_addr_q;
    wr_en_d   = 2'b00;
    done_d    = 1'b0;
    case (state_q)
      FILL: begin
        if (accept) begin
          dout_d    = din;
          sel_d     = tgt_q;
          wr_addr_d = cnt_q;
          wr_en_d   = tgt_q ? 2'b10 : 2'b01;
          if (cnt_q == LAST) begin
            // Releases already folded into full_d, so a same-cycle release avoids the stall.
            cnt_d         = '0;
            full_d[tgt_q] = 1'b1;
            done_d        = 1'b1;
            tgt_d         = ~tgt_q;
            if (full_d[~tgt_q]) state_d = STALL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      STALL: begin
        if (!full_d[tgt_q]) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FILL;
      tgt_q     <= 1'b0;
      cnt_q     <= '0;
      full_q    <= 2'b00;
      dout_q    <= '0;
      sel_q     <= 1'b0;
      wr_en_q   <= 2'b00;
      wr_addr_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
      full_q    <= full_d;
      dout_q    <= dout_d;
      sel_q     <= sel_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      done_q    <= done_d;
    end
  end

  assign dout        = dout_q;
  assign sel         = sel_q;
  assign wr_en_1     = wr_en_q[0];
  assign wr_en_2     = wr_en_q[1];
  assign wr_addr     = wr_addr_q;
  assign block_done  = done_q;
  assign bank_full_1 = full_q[0];
  assign bank_full_2 = full_q[1];

endmodule

// File: tb/tb_pingpong_stream_router.sv
// Randomized scoreboard bench: a stream-level model predicts each write and the ready/full flags.
module tb_pingpong_stream_router;
  localparam int DW = 8;
  localparam int BL = 4;
  localparam int AW = 2;

  logic          clk;
  logic          reset;
  logic [DW-1:0] din;
  logic          din_valid;
  logic          din_ready;
  logic          bank_release_1, bank_release_2;
  logic [DW-1:0] dout;
  logic          sel, wr_en_1, wr_en_2;
  logic [AW-1:0] wr_addr;
  logic          bank_full_1, bank_full_2, block_done;

  pingpong_stream_router #(.DATA_WIDTH(DW), .BLOCK_LEN(BL), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .bank_release_1(bank_release_1), .bank_release_2(bank_release_2),
    .dout(dout), .sel(sel), .wr_en_1(wr_en_1), .wr_en_2(wr_en_2), .wr_addr(wr_addr),
    .bank_full_1(bank_full_1), .bank_full_2(bank_full_2), .block_done(block_done)
  );

  typedef struct packed {
    logic [DW-1:0] data;
    logic          bank;
    logic [AW-1:0] addr;
    logic          done;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   nwrites = 0;

  // stream model state: pixels accepted since reset and which banks hold unreleased blocks
  int         n = 0;
  logic [1:0] full_m = 2'b00;
  bit         acc = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: checks current flags, then predicts what the coming edge does.
  always @(negedge clk) begin
    exp_t e;
    int   bank;
    logic rdy;
    if (reset) begin
      chk("din_ready_in_reset", {31'b0, din_ready}, 0);
      n = 0;
      full_m = 2'b00;
      acc = 1'b0;
    end else begin
      bank = (n / BL) % 2;
      rdy  = !full_m[bank];
      chk("din_ready", {31'b0, din_ready}, {31'b0, rdy});
      chk("bank_full_1", {31'b0, bank_full_1}, {31'b0, full_m[0]});
      chk("bank_full_2", {31'b0, bank_full_2}, {31'b0, full_m[1]});
      acc = din_valid && rdy;
      e = '0;
      if (acc) begin
        e.data = din;
        e.bank = bank[0];
        e.addr = AW'(n % BL);
        e.done = ((n % BL) == BL - 1);
        q.push_back(e);
        n++;
      end
      if (bank_release_1) full_m[0] = 1'b0;
      if (bank_release_2) full_m[1] = 1'b0;
      if (acc && e.done) full_m[bank] = 1'b1;
    end
  end

  // Monitor: pops an expectation whenever the DUT strobes a write.
  logic          rst_was = 1'b0;
  logic [DW-1:0] last_d = '0;
  logic          last_s = 1'b0;
  logic [AW-1:0] last_a = '0;
  always @(negedge clk) begin
    exp_t e;
    if (rst_was) begin
      chk("reset_outputs", {16'b0, dout, sel, wr_en_1, wr_en_2, wr_addr, bank_full_1,
                            bank_full_2, block_done}, 0);
      last_d = '0; last_s = 1'b0; last_a = '0;
    end else if (wr_en_1 || wr_en_2) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL write_without_accept got=write want=none t=%0t", $time);
      end else begin
        e = q.pop_front();
        chk("wr_en_exclusive", {31'b0, wr_en_1 & wr_en_2}, 0);
        chk("wr_bank", {31'b0, wr_en_2}, {31'b0, e.bank});
        chk("sel", {31'b0, sel}, {31'b0, e.bank});
        chk("dout", {24'b0, dout}, {24'b0, e.data});
        chk("wr_addr", {30'b0, wr_addr}, {30'b0, e.addr});
        chk("block_done", {31'b0, block_done}, {31'b0, e.done});
        nwrites++;
      end
      last_d = dout; last_s = sel; last_a = wr_addr;
    end else begin
      chk("idle_block_done", {31'b0, block_done}, 0);
      chk("idle_hold", {21'b0, dout, sel, wr_addr}, {21'b0, last_d, last_s, last_a});
    end
    if (reset) q.delete();
    rst_was = reset;
  end

  initial begin
    reset = 1'b1;
    din_valid = 1'b1;
    din = 8'hAA;
    bank_release_1 = 1'b0;
    bank_release_2 = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk);
      #1;
      if (acc || !din_valid) begin
        din_valid = ($urandom_range(0, 3) != 0);
        din = DW'($urandom);
      end
      // slow releases early on to force stalls, faster later for back-to-back fills
      bank_release_1 = (c < 2000) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) == 0);
      bank_release_2 = (c < 2000) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) == 0);
      reset = (c == 1500 || c == 3100);
    end
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    bank_release_1 = 1'b0;
    bank_release_2 = 1'b0;
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("queue_drained", q.size(), 0);
    chk("enough_writes", {31'b0, nwrites >= 500}, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pingpong_stream_router.md
# pingpong_stream_router

Upstream stage of the 8-bit 1-to-2 demux. It accepts a valid/ready pixel stream and drives the demux data and select lines. It also generates per-bank write enables and addresses, so that consecutive blocks of `BLOCK_LEN` pixels fill two feature-map banks alternately (ping-pong double buffering). A bank that has been filled is held until its consumer releases it; while the target bank is full, the input is back-pressured.

## Interface
- `DATA_WIDTH`, 8, pixel width; it must match the downstream demux width.
- `BLOCK_LEN`, 784, pixels per bank fill (one feature map, e.g. 28x28); must be ≥ 2.
- `ADDR_WIDTH`, 10, bank address width; requires 2^ADDR_WIDTH ≥ BLOCK_LEN.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `din`  in  DATA_WIDTH  input pixel.
- `din_valid`  in  1  `din` is valid.
- `din_ready`  out  1  router can accept a pixel this cycle.
- `bank_release_1`  in  1  one-cycle pulse: consumer has finished reading bank 1.
- `bank_release_2`  in  1  one-cycle pulse: consumer has finished reading bank 2.
- `dout`  out  DATA_WIDTH  registered pixel, to the demux `din`.
- `sel`  out  1  registered bank select, to the demux `sel`; 0 routes to bank 1 (`dout_1`), 1 routes to bank 2 (`dout_2`).
- `wr_en_1`  out  1  write strobe for bank 1.
- `wr_en_2`  out  1  write strobe for bank 2.
- `wr_addr`  out  ADDR_WIDTH  write address for the strobed bank.
- `bank_full_1`  out  1  bank 1 holds a complete, unreleased block.
- `bank_full_2`  out  1  bank 2 holds a complete, unreleased block.
- `block_done`  out  1  one-cycle pulse, aligned with the last write of a block.

## Operation
- **Internal state:**
  - `tgt`: the bank currently being filled; 0 selects bank 1.
  - `cnt`: 0..BLOCK_LEN-1.
  - `full[1:2]`.
  - FSM with states FILL and STALL.
- **FILL:**
  - `din_ready` = 1.
  - A beat is accepted when `din_valid` and `din_ready` are both 1.
  - On an accepted beat:
    - `dout` <= `din`, `sel` <= `tgt`, `wr_addr` <= `cnt`.
    - The `wr_en` of bank `tgt` is set to 1; the other `wr_en` is 0.
    - `cnt` increments.
  - The beat with `cnt` == BLOCK_LEN-1 ends the block. On that beat:
    - `cnt` <= 0, `full[tgt]` <= 1, `block_done` <= 1.
    - `tgt` toggles.
    - Next state is STALL if the new target bank is full (after that cycle's releases are applied), else FILL.
- **STALL:**
  - `din_ready` = 0, and both `wr_en` are 0.
  - Return to FILL in the cycle after `full[tgt]` clears.
- **Release:**
  - `bank_release_k` clears `full[k]` at the next edge.
  - A release of a bank that is not full is ignored. This includes the bank currently being filled mid-block; `cnt` is unaffected.
  - Release of the other bank in the same cycle as block completion: both take effect. `full[old tgt]` = 1 and `full[other]` = 0, so the FSM stays in FILL with no bubble.
  - Both releases in the same cycle: both flags clear.
- **No-beat cycles:** both `wr_en` = 0 and `block_done` = 0. `dout`, `sel` and `wr_addr` hold their last values.
- **`cnt` wrap:** `cnt` wraps only at BLOCK_LEN-1, never at 2^ADDR_WIDTH.
- **Reset:**
  - Internal state: `tgt` = 0, `cnt` = 0, `full` = 0, FSM = FILL.
  - All outputs: `dout` = 0, `sel` = 0, `wr_en_1` = 0, `wr_en_2` = 0, `wr_addr` = 0, `bank_full_1` = 0, `bank_full_2` = 0, `block_done` = 0.
  - `din_ready` is forced to 0 while `reset` is high.
  - Reset mid-block discards the partial block, and any full flags are dropped.

## Timing
- Latency from an accepted `din` to `dout`/`sel`/`wr_en`/`wr_addr`: exactly 1 cycle. All four are registered together, so the combinational demux sees data and select aligned.
- `din_ready` is a decode of registered state only; there is no combinational path from `din_valid` or `bank_release_*`.
- `bank_full_k` reflects `full[k]` directly.
- `block_done` is high in the same cycle as the write of address BLOCK_LEN-1.
- Throughput is 1 pixel/cycle in FILL. No bubble at the block boundary when the next bank is free.
- Release to resume: `bank_release` at cycle t → `din_ready` = 1 at t+1 (if stalled on that bank) → first write at t+2.

## Test plan
Tests use BLOCK_LEN=4, ADDR_WIDTH=2.
- **Reset:** hold `reset` 2 cycles with `din_valid`=1 → all outputs 0 and `din_ready`=0; first cycle after reset, `din_ready`=1.
- **Single block:** stream 0x10..0x13 back-to-back → writes to bank 1 at addr 0..3 on cycles 1..4 with `sel`=0; `block_done` and `bank_full_1` set at addr 3; the next beat 0x14 goes to bank 2 addr 0 with `sel`=1.
- **Back-pressure:** stream 9 pixels with no releases → 8 writes (bank 1 then bank 2); `din_ready`=0 after the 8th accept; the 9th pixel is held. Pulse `bank_release_1` → 9th pixel written to bank 1 addr 0 two cycles later.
- **Simultaneous events:** `bank_release_2` in the same cycle as the last beat of a bank-1 block (bank 2 full) → no stall, next beat goes to bank 2 addr 0.
- **Spurious release:** `bank_release_1` asserted mid-fill of bank 1 (`cnt`=2) → ignored; writes continue at addr 2, 3, then `bank_full_1`=1.
- **Reset mid-operation:** assert `reset` at `cnt`=2 of bank 2 with `bank_full_1`=1 → next fill starts at bank 1 addr 0, both full flags 0.
